// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
//   Shared types for the Life command path.
//   cmd_t         : command encoding on the pe_array command bus (pe_array
//                   imports the same type).
//   sched_state_t : life_cmd_scheduler FSM states.
//   grant_t       : arbitration result of life_sched_arb.
//   grant_to_cmd  : maps a grant onto the command it issues.
// ---------------------------------------------------------------------------
package life_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DONE       = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CLR  = 2'd1,
    G_WR   = 2'd2,
    G_STEP = 2'd3
  } grant_t;

  // Number of consecutive grants a pending step may lose to writes before
  // it is forced through.
  localparam int LOSS_LIMIT = 2;

  // Overrun counter saturation value.
  localparam logic [7:0] OVR_MAX = 8'hFF;

  function automatic cmd_t grant_to_cmd(input grant_t g);
    cmd_t c;
    case (g)
      G_CLR:   c = CMD_CLEAR;
      G_WR:    c = CMD_WRITE;
      G_STEP:  c = CMD_STEP;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/life_sched_arb.sv
// ---------------------------------------------------------------------------
// life_sched_arb
//   Combinational request picker for life_cmd_scheduler.
//   Fixed priority clear > write > step, except that a step which has
//   already lost LOSS_LIMIT consecutive grants to writes beats a write.
// Ports
//   en        in  1   arbitration window open (scheduler ready to grant)
//   clr_pend  in  1   clear requested
//   wr_pend   in  1   write requested
//   step_pend in  1   step requested
//   loss_cnt  in  2   consecutive grants the pending step lost to writes
//   grant     out 2   grant_t encoding of the winner (G_NONE if none/!en)
// ---------------------------------------------------------------------------
module life_sched_arb
  import life_pkg::*;
(
  input  logic       en,
  input  logic       clr_pend,
  input  logic       wr_pend,
  input  logic       step_pend,
  input  logic [1:0] loss_cnt,
  output logic [1:0] grant
);

  grant_t pick;
  logic   step_forced;

  assign step_forced = (loss_cnt >= 2'(LOSS_LIMIT));

  always_comb begin
    pick = G_NONE;
    if (en) begin
      if (clr_pend) begin
        pick = G_CLR;
      end else if (step_pend && (!wr_pend || step_forced)) begin
        pick = G_STEP;
      end else if (wr_pend) begin
        pick = G_WR;
      end
    end
  end

  assign grant = pick;

endmodule

// File: rtl/life_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// life_cmd_scheduler
//   Sole command master of pe_array. Arbitrates clear / cell-write /
//   generation-step requests, issues one command at a time, waits for the
//   array's active flag to rise and fall, then acknowledges the requester.
//   Counts completed generations and dropped timer ticks.
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   run_en, tick          free-run enable and timer step trigger
//   step_req              manual single-step pulse
//   clr_req / clr_ack     clear request pulse / completion pulse
//   wr_req / wr_ack       level write request (with wr_x, wr_y, wr_val) /
//                         completion pulse
//   active                pe_array busy flag
//   cmd, adr_x, adr_y,    registered command bus to pe_array
//   state_in
//   busy                  scheduler not in IDLE
//   gen_count             completed steps (wraps)
//   ovr_cnt               ticks dropped because a step was already pending
//                         (saturates at 255)
//   tmo_err               sticky: active stayed high for DONE_TMO cycles
// ---------------------------------------------------------------------------
module life_cmd_scheduler
  import life_pkg::*;
#(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 5,
  parameter int STATE_BITS = 1,
  parameter int GEN_BITS   = 16,
  parameter int ACK_WAIT   = 4,
  parameter int DONE_TMO   = 1024
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_en,
  input  logic                  tick,
  input  logic                  step_req,
  input  logic                  clr_req,
  output logic                  clr_ack,
  input  logic                  wr_req,
  input  logic [X_BITS-1:0]     wr_x,
  input  logic [Y_BITS-1:0]     wr_y,
  input  logic [STATE_BITS-1:0] wr_val,
  output logic                  wr_ack,
  input  logic                  active,
  output logic [1:0]            cmd,
  output logic [X_BITS-1:0]     adr_x,
  output logic [Y_BITS-1:0]     adr_y,
  output logic [STATE_BITS-1:0] state_in,
  output logic                  busy,
  output logic [GEN_BITS-1:0]   gen_count,
  output logic [7:0]            ovr_cnt,
  output logic                  tmo_err
);

  // One counter serves both the start window and the completion timeout.
  localparam int TMR_MAX  = (DONE_TMO > ACK_WAIT) ? DONE_TMO : ACK_WAIT;
  localparam int TMR_BITS = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  sched_state_t          state_reg, state_next;
  grant_t                grant_reg, grant_next;
  cmd_t                  cmd_reg, cmd_next;
  logic [X_BITS-1:0]     adr_x_reg, adr_x_next;
  logic [Y_BITS-1:0]     adr_y_reg, adr_y_next;
  logic [STATE_BITS-1:0] state_in_reg, state_in_next;
  logic [TMR_BITS-1:0]   tmr_reg, tmr_next;
  logic                  clr_pend_reg, clr_pend_next;
  logic                  step_pend_reg, step_pend_next;
  logic [1:0]            loss_reg, loss_next;
  logic [GEN_BITS-1:0]   gen_reg, gen_next;
  logic [7:0]            ovr_reg, ovr_next;
  logic                  tmo_reg, tmo_next;
  logic                  hold_reg;

  logic       tick_step;
  logic       step_in;
  logic       clr_eff;
  logic       step_eff;
  logic       arb_en;
  logic [1:0] arb_grant;
  grant_t     arb_pick;

  assign tick_step = tick & run_en;
  assign step_in   = tick_step | step_req;

  // Requests arriving in the granting cycle are considered directly so a
  // request seen in cycle 0 puts its command on the bus in cycle 1.
  assign clr_eff  = clr_pend_reg | clr_req;
  assign step_eff = step_pend_reg | step_in;

  // The IDLE cycle right after DONE grants nothing: the write requester
  // only lowers wr_req after seeing wr_ack, so its request is stale there.
  assign arb_en = (state_reg == S_IDLE) && !hold_reg;

  life_sched_arb u_arb (
    .en        (arb_en),
    .clr_pend  (clr_eff),
    .wr_pend   (wr_req),
    .step_pend (step_eff),
    .loss_cnt  (loss_reg),
    .grant     (arb_grant)
  );

  assign arb_pick = grant_t'(arb_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      grant_reg     <= G_NONE;
      cmd_reg       <= CMD_NOP;
      adr_x_reg     <= '0;
      adr_y_reg     <= '0;
      state_in_reg  <= '0;
      tmr_reg       <= '0;
      clr_pend_reg  <= 1'b0;
      step_pend_reg <= 1'b0;
      loss_reg      <= '0;
      gen_reg       <= '0;
      ovr_reg       <= '0;
      tmo_reg       <= 1'b0;
      hold_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      cmd_reg       <= cmd_next;
      adr_x_reg     <= adr_x_next;
      adr_y_reg     <= adr_y_next;
      state_in_reg  <= state_in_next;
      tmr_reg       <= tmr_next;
      clr_pend_reg  <= clr_pend_next;
      step_pend_reg <= step_pend_next;
      loss_reg      <= loss_next;
      gen_reg       <= gen_next;
      ovr_reg       <= ovr_next;
      tmo_reg       <= tmo_next;
      hold_reg      <= (state_reg == S_DONE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    cmd_next       = CMD_NOP;   // a command is on the bus for one cycle only
    adr_x_next     = adr_x_reg;
    adr_y_next     = adr_y_reg;
    state_in_next  = state_in_reg;
    tmr_next       = tmr_reg;
    clr_pend_next  = clr_pend_reg;
    step_pend_next = step_pend_reg;
    loss_next      = loss_reg;
    gen_next       = gen_reg;
    ovr_next       = ovr_reg;
    tmo_next       = tmo_reg;

    // Request capture. A repeated clear simply stays set (absorbed); a
    // timer tick that finds a step already pending is counted as dropped.
    if (clr_req) begin
      clr_pend_next = 1'b1;
    end
    if (step_in) begin
      step_pend_next = 1'b1;
    end
    if (tick_step && step_pend_reg && (ovr_reg != OVR_MAX)) begin
      ovr_next = ovr_reg + 8'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (arb_pick != G_NONE) begin
          grant_next    = arb_pick;
          cmd_next      = grant_to_cmd(arb_pick);
          adr_x_next    = '0;
          adr_y_next    = '0;
          state_in_next = '0;
          tmr_next      = '0;
          state_next    = S_ISSUE;
          case (arb_pick)
            G_WR: begin
              adr_x_next    = wr_x;
              adr_y_next    = wr_y;
              state_in_next = wr_val;
              if (step_eff && (loss_reg != 2'd3)) begin
                loss_next = loss_reg + 2'd1;
              end
            end
            G_STEP: begin
              // The step request is retired as soon as it is granted, so a
              // tick arriving while this step runs queues exactly one more
              // step and only further ticks count as overruns.
              step_pend_next = 1'b0;
              loss_next      = '0;
            end
            default: ;
          endcase
        end
      end

      S_ISSUE: begin
        tmr_next   = '0;
        state_next = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (active) begin
          tmr_next   = '0;
          state_next = S_WAIT_DONE;
        end else if (tmr_reg == TMR_BITS'(ACK_WAIT - 1)) begin
          // Command finished inside one cycle and active never showed.
          state_next = S_DONE;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!active) begin
          state_next = S_DONE;
        end else if (tmr_reg == TMR_BITS'(DONE_TMO - 1)) begin
          tmo_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
        case (grant_reg)
          G_STEP: begin
            gen_next = gen_reg + GEN_BITS'(1);
          end
          G_CLR: begin
            // A step requested alongside or behind the clear is kept and
            // runs on the cleared board.
            clr_pend_next = 1'b0;
            ovr_next      = '0;
            tmo_next      = 1'b0;
            gen_next      = '0;
          end
          default: ;
        endcase
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign cmd       = cmd_reg;
  assign adr_x     = adr_x_reg;
  assign adr_y     = adr_y_reg;
  assign state_in  = state_in_reg;
  assign busy      = (state_reg != S_IDLE);
  assign gen_count = gen_reg;
  assign ovr_cnt   = ovr_reg;
  assign tmo_err   = tmo_reg;
  assign clr_ack   = (state_reg == S_DONE) && (grant_reg == G_CLR);
  assign wr_ack    = (state_reg == S_DONE) && (grant_reg == G_WR);

endmodule
